// File: rtl/wide_pipe_pkg.sv
// Shared constants and helpers for the wide elastic pipeline.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package wide_pipe_pkg;

  // Deepest pipeline the block is built for; sizes the popcount helper.
  localparam int MAX_DEPTH = 8;

  // Number of set bits in a stage-valid vector, used to cross-check occupancy.
  function automatic int popcount(input logic [MAX_DEPTH-1:0] bits);
    int n;
    n = 0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n = n + (bits[i] ? 1 : 0);
    end
    return n;
  endfunction

endpackage

// File: rtl/wide_pipe_stage.sv
// Single elastic register stage: valid bit plus WIDTH-bit payload.
// Latency: one cycle from up_adv to stg_valid.
// Backpressure: holds its word until dn_ready (this stage advancing) is seen.
module wide_pipe_stage
  import wide_pipe_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_adv,
  input  logic             dn_ready,
  output logic             stg_valid,
  output logic [WIDTH-1:0] stg_data
);

  // Payload width follows the stage parameter, so the record type lives here.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t stg_q;
  stage_t stg_d;

  // Drain when this stage advances, reload when the upstream side advances into it;
  // flush drops validity but leaves the payload untouched.
  always_comb begin
    stg_d = stg_q;
    if (dn_ready) begin
      stg_d.valid = 1'b0;
    end
    if (up_adv && up_valid && !flush) begin
      stg_d.valid = 1'b1;
      stg_d.data  = up_data;
    end
    if (flush) begin
      stg_d.valid = 1'b0;
    end
  end

  // Stage register; reset clears both the valid bit and the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_q <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  assign stg_valid = stg_q.valid;
  assign stg_data  = stg_q.data;

endmodule

// File: rtl/wide_pipe_buf.sv
// Elastic DEPTH-stage retiming pipeline for wide buses with flush and occupancy count.
// Latency: DEPTH cycles from acceptance to out_valid on an empty pipe; one word per cycle sustained.
// Backpressure: combinational ready chain, so in_ready rises in the same cycle out_ready does.
module wide_pipe_buf
  import wide_pipe_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 2,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  occupancy
);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];
  logic             accept;
  logic             emit;
  logic [CNTW-1:0]  occ_q;
  logic [CNTW-1:0]  occ_d;

  // Ready chain, walked from the output stage back to stage 0: a stage moves when
  // it holds a word and the stage ahead is empty or moving itself.
  always_comb begin
    logic carry;
    carry = out_ready;
    adv   = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k] = v[k] & carry;
      carry  = ~v[k] | (v[k] & carry);
    end
  end

  assign in_ready = ~rst & ~flush & (~v[0] | adv[0]);
  assign accept   = in_valid & in_ready;
  assign emit     = v[DEPTH-1] & out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             up_v;
    logic             up_a;
    logic [WIDTH-1:0] up_d;

    if (k == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = in_data;
      assign up_a = accept;
    end else begin : g_body
      assign up_v = v[k-1];
      assign up_d = d[k-1];
      assign up_a = adv[k-1];
    end

    wide_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .up_valid  (up_v),
      .up_data   (up_d),
      .up_adv    (up_a),
      .dn_ready  (adv[k]),
      .stg_valid (v[k]),
      .stg_data  (d[k])
    );
  end

  // Occupancy follows accepts minus emits; flush empties it regardless of the handshake.
  always_comb begin
    occ_d = occ_q + CNTW'(accept) - CNTW'(emit);
    if (flush) begin
      occ_d = '0;
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign occupancy = occ_q;

  // Valid bits widened to the helper's fixed width for the consistency checks.
  logic [MAX_DEPTH-1:0] v_ext;
  always_comb begin
    v_ext            = '0;
    v_ext[DEPTH-1:0] = v;
  end

  a_occ_matches_valid: assert property (@(posedge clk) disable iff (rst)
    popcount(v_ext) == int'(occ_q));
  a_occ_bounded: assert property (@(posedge clk) disable iff (rst)
    int'(occ_q) <= DEPTH);

endmodule

// File: tb/tb_wide_pipe_buf.sv
// Bench for wide_pipe_buf: directed vector table, a full-pipe streaming sequence,
// then randomized traffic on three parameterisations against a queue-based model.
module tb_wide_pipe_buf;

  localparam int W0 = 128;
  localparam int D0 = 2;
  localparam int W1 = 1;
  localparam int D1 = 1;
  localparam int W2 = 1024;
  localparam int D2 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT0: default 128 x 2
  logic          rst0 = 1'b1, flush0 = 1'b0, iv0 = 1'b0, ordy0 = 1'b0;
  logic [W0-1:0] din0 = '0;
  logic          irdy0, ovld0;
  logic [W0-1:0] dout0;
  logic [1:0]    occ0;
  // DUT1: 1 x 1
  logic          rst1 = 1'b1, flush1 = 1'b0, iv1 = 1'b0, ordy1 = 1'b0;
  logic [W1-1:0] din1 = '0;
  logic          irdy1, ovld1;
  logic [W1-1:0] dout1;
  logic [0:0]    occ1;
  // DUT2: 1024 x 8
  logic          rst2 = 1'b1, flush2 = 1'b0, iv2 = 1'b0, ordy2 = 1'b0;
  logic [W2-1:0] din2 = '0;
  logic          irdy2, ovld2;
  logic [W2-1:0] dout2;
  logic [3:0]    occ2;

  wide_pipe_buf #(.WIDTH(W0), .DEPTH(D0)) dut0 (
    .clk(clk), .rst(rst0), .flush(flush0), .in_valid(iv0), .in_ready(irdy0), .in_data(din0),
    .out_valid(ovld0), .out_ready(ordy0), .out_data(dout0), .occupancy(occ0));
  wide_pipe_buf #(.WIDTH(W1), .DEPTH(D1)) dut1 (
    .clk(clk), .rst(rst1), .flush(flush1), .in_valid(iv1), .in_ready(irdy1), .in_data(din1),
    .out_valid(ovld1), .out_ready(ordy1), .out_data(dout1), .occupancy(occ1));
  wide_pipe_buf #(.WIDTH(W2), .DEPTH(D2)) dut2 (
    .clk(clk), .rst(rst2), .flush(flush2), .in_valid(iv2), .in_ready(irdy2), .in_data(din2),
    .out_valid(ovld2), .out_ready(ordy2), .out_data(dout2), .occupancy(occ2));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act[191:0], exp[191:0]);
    end
  endtask

  // Reference model: an ordered queue of words plus the edge count at which each was
  // accepted. The oldest word reaches the output once it has aged DEPTH edges; the pipe
  // accepts whenever it is not full or the consumer is taking a word.
  logic [1023:0] mq [3][$];
  int            ma [3][$];
  int            mcyc [3];
  bit            seen [3];

  task automatic model_step(input int id, input int depth, input logic r, input logic f,
                            input logic iv, input logic ordy, input logic [1023:0] idat,
                            input logic irdy_o, input logic ovld_o,
                            input logic [1023:0] odat_o, input int occ_o);
    int   sz;
    logic e_ovld;
    logic e_irdy;
    sz     = mq[id].size();
    e_ovld = 1'b0;
    if (sz > 0) e_ovld = (mcyc[id] - ma[id][0]) >= depth;
    e_irdy = !r && !f && ((sz < depth) || ordy);
    if (seen[id]) begin
      chk($sformatf("d%0d in_ready", id), 1024'(irdy_o), 1024'(e_irdy));
      chk($sformatf("d%0d out_valid", id), 1024'(ovld_o), 1024'(e_ovld));
      chk($sformatf("d%0d occupancy", id), 1024'(occ_o), 1024'(sz));
      if (e_ovld) chk($sformatf("d%0d out_data", id), odat_o, mq[id][0]);
    end
    if (r) begin
      mq[id].delete();
      ma[id].delete();
      seen[id] = 1'b1;
    end else begin
      if (e_ovld && ordy) begin
        void'(mq[id].pop_front());
        void'(ma[id].pop_front());
      end
      if (f) begin
        mq[id].delete();
        ma[id].delete();
      end
      if (iv && e_irdy) begin
        mq[id].push_back(idat);
        ma[id].push_back(mcyc[id]);
      end
    end
    mcyc[id]++;
  endtask

  // Model evaluation mid-cycle, when inputs and combinational outputs are settled.
  always @(negedge clk) begin
    model_step(0, D0, rst0, flush0, iv0, ordy0, 1024'(din0), irdy0, ovld0, 1024'(dout0), int'(occ0));
    model_step(1, D1, rst1, flush1, iv1, ordy1, 1024'(din1), irdy1, ovld1, 1024'(dout1), int'(occ1));
    model_step(2, D2, rst2, flush2, iv2, ordy2, 1024'(din2), irdy2, ovld2, 1024'(dout2), int'(occ2));
  end

  typedef struct {
    logic          rst, flush, iv, ordy;
    logic [W0-1:0] din;
    logic          irdy, ovld;
    logic [W0-1:0] dout;
    int            occ;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic r, input logic f, input logic iv, input logic ordy,
                     input logic [W0-1:0] din, input logic irdy, input logic ovld,
                     input logic [W0-1:0] dout, input int occ);
    vec_t t;
    t.rst = r; t.flush = f; t.iv = iv; t.ordy = ordy; t.din = din;
    t.irdy = irdy; t.ovld = ovld; t.dout = dout; t.occ = occ;
    tbl.push_back(t);
  endtask

  initial begin
    logic [W0-1:0] a5;
    logic [W0-1:0] x5a;
    a5  = {16{8'hA5}};
    x5a = {16{8'h5A}};
    for (int i = 0; i < 3; i++) begin
      mcyc[i] = 0;
      seen[i] = 1'b0;
    end
    // rst flush iv ordy din | in_ready out_valid out_data occ
    add(1, 0, 0, 0, 0,     0, 0, 0,     0);  // reset state
    add(1, 0, 0, 0, 0,     0, 0, 0,     0);
    add(0, 0, 1, 1, 0,     1, 0, 0,     0);  // stream 0,1,2,3
    add(0, 0, 1, 1, 1,     1, 0, 0,     1);
    add(0, 0, 1, 1, 2,     1, 1, 0,     2);  // first out_valid two cycles after accept
    add(0, 0, 1, 1, 3,     1, 1, 1,     2);
    add(0, 0, 0, 0, 0,     0, 1, 2,     2);  // full and stalled
    add(0, 0, 0, 1, 0,     1, 1, 2,     2);  // ready returns same cycle
    add(0, 0, 0, 1, 0,     1, 1, 3,     1);
    add(0, 0, 1, 0, a5,    1, 0, 3,     0);  // back-pressure fill
    add(0, 0, 1, 0, x5a,   1, 0, 3,     1);
    add(0, 0, 1, 0, 'h77,  0, 1, a5,    2);
    add(0, 0, 1, 0, 'h77,  0, 1, a5,    2);  // held stable
    add(0, 0, 0, 1, 0,     1, 1, a5,    2);
    add(0, 0, 0, 1, 0,     1, 1, x5a,   1);
    add(0, 0, 0, 1, 0,     1, 0, x5a,   0);
    add(0, 0, 1, 0, 'h10,  1, 0, x5a,   0);  // flush mid-stream
    add(0, 0, 1, 0, 'h11,  1, 0, x5a,   1);
    add(0, 1, 1, 0, 'h12,  0, 1, 'h10,  2);
    add(0, 0, 1, 1, 1,     1, 0, 'h10,  0);
    add(0, 0, 0, 1, 0,     1, 0, 'h10,  1);
    add(0, 0, 0, 1, 0,     1, 1, 1,     1);
    add(0, 0, 1, 0, 'h20,  1, 0, 1,     0);  // reset mid-operation
    add(1, 0, 0, 0, 0,     0, 0, 1,     1);
    add(0, 0, 0, 1, 0,     1, 0, 0,     0);
    add(0, 0, 0, 1, 0,     1, 0, 0,     0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      rst0 = tbl[i].rst; flush0 = tbl[i].flush; iv0 = tbl[i].iv;
      ordy0 = tbl[i].ordy; din0 = tbl[i].din;
      @(negedge clk);
      chk($sformatf("tbl%0d in_ready", i), 1024'(irdy0), 1024'(tbl[i].irdy));
      chk($sformatf("tbl%0d out_valid", i), 1024'(ovld0), 1024'(tbl[i].ovld));
      chk($sformatf("tbl%0d out_data", i), 1024'(dout0), 1024'(tbl[i].dout));
      chk($sformatf("tbl%0d occupancy", i), 1024'(occ0), 1024'(tbl[i].occ));
    end

    // Full pipe with simultaneous accept and emit for 10 cycles.
    @(posedge clk); #1;
    rst0 = 1'b0; flush0 = 1'b0; iv0 = 1'b1; ordy0 = 1'b0; din0 = 100;
    @(posedge clk); #1;
    din0 = 101;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      din0 = W0'(102 + i); ordy0 = 1'b1;
      @(negedge clk);
      chk($sformatf("full%0d occupancy", i), 1024'(occ0), 1024'(2));
      chk($sformatf("full%0d out_data", i), 1024'(dout0), 1024'(100 + i));
      chk($sformatf("full%0d in_ready", i), 1024'(irdy0), 1024'(1));
    end
    @(posedge clk); #1;
    iv0 = 1'b0;

    // Randomized traffic on all three configurations.
    for (int c = 0; c < 2000; c++) begin
      int bias;
      @(posedge clk); #1;
      bias   = (c < 1000) ? 35 : 75;
      rst0   = ($urandom_range(0, 299) == 0);
      rst1   = (c < 2) || ($urandom_range(0, 299) == 0);
      rst2   = (c < 2) || ($urandom_range(0, 299) == 0);
      flush0 = ($urandom_range(0, 39) == 0);
      flush1 = ($urandom_range(0, 39) == 0);
      flush2 = ($urandom_range(0, 39) == 0);
      iv0    = ($urandom_range(0, 99) < 70);
      iv1    = ($urandom_range(0, 99) < 70);
      iv2    = ($urandom_range(0, 99) < 70);
      ordy0  = ($urandom_range(0, 99) < bias);
      ordy1  = ($urandom_range(0, 99) < bias);
      ordy2  = ($urandom_range(0, 99) < bias);
      din0   = {$urandom, $urandom, $urandom, $urandom};
      din1   = W1'($urandom);
      for (int w = 0; w < 32; w++) din2[w*32 +: 32] = $urandom;
    end
    @(posedge clk); #1;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    flush0 = 1'b0; flush1 = 1'b0; flush2 = 1'b0;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    ordy0 = 1'b1; ordy1 = 1'b1; ordy2 = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
